// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU memory interface.
// Serves single-edge reads/writes to an internal RAM plus two I/O registers:
// a write-only LED register (readable back) and a synchronised switch input.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   mem_cmd     1=MREAD, 3=MWRITE, 0/2=MNONE
//   mem_addr    word address
//   write_data  store data, used with MWRITE
//   read_data   registered read result (one-cycle latency)
//   rd_valid    one-cycle pulse after a read updated read_data
//   err         one-cycle pulse after an access to an unmapped/illegal address
//   sw_in       asynchronous switch inputs
//   led_out     LED register
//   rd_count    saturating count of accepted reads
//   wr_count    saturating count of accepted writes (including ignored ones)
module mem_responder #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 9,
  parameter int unsigned       RAM_WORDS = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140,
  parameter int unsigned       IO_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic              err,
  input  logic [IO_W-1:0]   sw_in,
  output logic [IO_W-1:0]   led_out,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int unsigned       RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [ADDR_W:0]   RAM_LIMIT = (ADDR_W + 1)'(RAM_WORDS);
  localparam logic [15:0]       CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    CmdNoneZero = 2'd0,
    CmdRead     = 2'd1,
    CmdNone     = 2'd2,
    CmdWrite    = 2'd3
  } cmd_e;

  logic [DATA_W-1:0] ram [RAM_WORDS];

  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;
  logic [IO_W-1:0]   led_q, led_d;
  logic [15:0]       rd_count_q, rd_count_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [IO_W-1:0]   sw_meta_q, sw_sync_q;

  logic              is_read, is_write;
  logic              hit_ram, hit_led, hit_sw;
  logic [RAM_AW-1:0] ram_idx;

  // Address and command decode
  always_comb begin
    is_read  = (mem_cmd == CmdRead);
    is_write = (mem_cmd == CmdWrite);
    hit_ram  = ({1'b0, mem_addr} < RAM_LIMIT);
    hit_led  = (mem_addr == LED_ADDR);
    hit_sw   = (mem_addr == SW_ADDR);
    ram_idx  = mem_addr[RAM_AW-1:0];
  end

  // Next-state for read path, I/O register, status pulses and counters
  always_comb begin
    read_data_d = read_data_q;
    rd_valid_d  = 1'b0;
    err_d       = 1'b0;
    led_d       = led_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;

    if (is_read) begin
      rd_valid_d = 1'b1;
      if (rd_count_q != CNT_MAX) rd_count_d = rd_count_q + 16'd1;
      if (hit_ram) begin
        read_data_d = ram[ram_idx];
      end else if (hit_sw) begin
        read_data_d = {{(DATA_W - IO_W){1'b0}}, sw_sync_q};
      end else if (hit_led) begin
        read_data_d = {{(DATA_W - IO_W){1'b0}}, led_q};
      end else begin
        read_data_d = '0;
        err_d       = 1'b1;
      end
    end else if (is_write) begin
      if (wr_count_q != CNT_MAX) wr_count_d = wr_count_q + 16'd1;
      if (hit_led) begin
        led_d = write_data[IO_W-1:0];
      end else if (!hit_ram) begin
        // Switch register is read-only, so a write to it is an error too
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      led_q       <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
    end else begin
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
      led_q       <= led_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      sw_meta_q   <= sw_in;
      sw_sync_q   <= sw_meta_q;
    end
  end

  // RAM has no reset; writes are blocked while reset is held
  always_ff @(posedge clk) begin
    if (!reset && is_write && hit_ram) begin
      ram[ram_idx] <= write_data;
    end
  end

  assign read_data = read_data_q;
  assign rd_valid  = rd_valid_q;
  assign err       = err_q;
  assign led_out   = led_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder with a behavioural model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        rd_valid;
  logic        err;
  logic [7:0]  sw_in;
  logic [7:0]  led_out;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .rd_valid   (rd_valid),
    .err        (err),
    .sw_in      (sw_in),
    .led_out    (led_out),
    .rd_count   (rd_count),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [15:0] m_ram [256];
  logic [7:0]  m_led;
  logic [7:0]  m_sw1, m_sw2;
  logic [15:0] m_rdata;
  logic        m_rv, m_err;
  int          m_rd, m_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_led   = '0;
    m_sw1   = '0;
    m_sw2   = '0;
    m_rdata = '0;
    m_rv    = 1'b0;
    m_err   = 1'b0;
    m_rd    = 0;
    m_wr    = 0;
  endtask

  // One clock edge of the memory map's behaviour, in plain terms
  task automatic model_edge(input logic [1:0] cmd, input logic [8:0] addr,
                            input logic [15:0] wd, input logic [7:0] sw);
    int a;
    a     = int'(addr);
    m_rv  = 1'b0;
    m_err = 1'b0;
    if (cmd == 2'd1) begin
      m_rv = 1'b1;
      if (m_rd < 65535) m_rd++;
      if (a < 256)        m_rdata = m_ram[a];
      else if (a == 'h140) m_rdata = {8'h00, m_sw2};
      else if (a == 'h100) m_rdata = {8'h00, m_led};
      else begin
        m_rdata = 16'h0000;
        m_err   = 1'b1;
      end
    end else if (cmd == 2'd3) begin
      if (m_wr < 65535) m_wr++;
      if (a < 256)         m_ram[a] = wd;
      else if (a == 'h100) m_led = wd[7:0];
      else                 m_err = 1'b1;
    end
    m_sw2 = m_sw1;
    m_sw1 = sw;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".read_data"}, 32'(read_data), 32'(m_rdata));
    check({tag, ".rd_valid"},  32'(rd_valid),  32'(m_rv));
    check({tag, ".err"},       32'(err),       32'(m_err));
    check({tag, ".led_out"},   32'(led_out),   32'(m_led));
    check({tag, ".rd_count"},  32'(rd_count),  32'(m_rd));
    check({tag, ".wr_count"},  32'(wr_count),  32'(m_wr));
  endtask

  // Drive a command, take one edge, update the model, check #1 later
  task automatic step(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                      input string tag, input bit do_check = 1'b1);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
    @(posedge clk);
    model_edge(cmd, addr, wd, sw_in);
    #1;
    if (do_check) check_all(tag);
  endtask

  function automatic logic [8:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return {1'b0, 8'($urandom)};
      2:       return ($urandom_range(0, 1) == 0) ? 9'h100 : 9'h140;
      default: return 9'($urandom);
    endcase
  endfunction

  initial begin
    reset      = 1'b1;
    mem_cmd    = 2'd2;
    mem_addr   = '0;
    write_data = '0;
    sw_in      = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    reset = 1'b0;

    // Give every RAM word a known value
    for (int i = 0; i < 256; i++) step(2'd3, 9'(i), 16'($urandom), "init");

    // Reset mid-operation with a write held across two edges
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    mem_cmd    = 2'd3;
    mem_addr   = 9'd5;
    write_data = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_held");
    reset = 1'b0;
    step(2'd0, 9'd5, 16'hBEEF, "rst_release");
    check("rst_release.read_data_zero", 32'(read_data), 32'h0);

    // Write then read back-to-back
    step(2'd3, 9'h003, 16'h1234, "wr3");
    step(2'd1, 9'h003, 16'h0000, "rd3");
    check("rd3.value", 32'(read_data), 32'h1234);
    check("rd3.counts", {rd_count, wr_count}, {16'd1, 16'd1});
    step(2'd2, 9'h003, 16'h0000, "rd3_after");
    check("rd3.valid_drop", 32'(rd_valid), 32'h0);

    // RAM word 5 kept its pre-reset value
    step(2'd1, 9'd5, 16'h0000, "rd5");
    check("rd5.not_beef", 32'(read_data != 16'hBEEF || m_ram[5] == 16'hBEEF), 32'h1);

    // LED write and readback
    step(2'd3, 9'h100, 16'hA55A, "led_wr");
    check("led_wr.value", 32'(led_out), 32'h5A);
    step(2'd1, 9'h100, 16'h0000, "led_rd");
    check("led_rd.value", 32'(read_data), 32'h005A);

    // Switch synchroniser latency
    sw_in = 8'h00;
    repeat (3) step(2'd2, 9'h000, 16'h0000, "sw_idle");
    sw_in = 8'h3C;
    step(2'd1, 9'h140, 16'h0000, "sw_rd1");
    check("sw_rd1.stale", 32'(read_data), 32'h0);
    step(2'd1, 9'h140, 16'h0000, "sw_rd2");
    step(2'd1, 9'h140, 16'h0000, "sw_rd3");
    check("sw_rd3.value", 32'(read_data), 32'h003C);

    // Unmapped read and illegal write
    step(2'd1, 9'h1F0, 16'h0000, "unm_rd");
    check("unm_rd.pulse", {read_data, 15'd0, err}, {16'h0, 15'd0, 1'b1});
    step(2'd3, 9'h140, 16'hFFFF, "sw_wr");
    check("sw_wr.err", 32'(err), 32'h1);
    check("sw_wr.led", 32'(led_out), 32'h5A);
    step(2'd2, 9'h140, 16'h0000, "err_drop");
    check("err_drop.err", 32'(err), 32'h0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) sw_in = 8'($urandom);
      step(2'($urandom), rand_addr(), 16'($urandom), "rand");
    end

    // Read counter saturation
    for (int i = 0; i < 65540; i++) begin
      step(2'd1, {1'b0, 8'($urandom)}, 16'h0000, "sat", (i % 1024) == 0 || i > 65530);
    end
    check("sat.rd_count", 32'(rd_count), 32'hFFFF);
    step(2'd2, 9'h000, 16'h0000, "hold1");
    step(2'd0, 9'h1FF, 16'h0000, "hold2");
    check("hold.rd_count", 32'(rd_count), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU memory interface.
- Samples mem_cmd, mem_addr and write_data from the CPU each clock.
- Serves reads and writes to an internal 256x16 RAM, plus two memory-mapped I/O locations: an LED output register and a synchronised switch input.
- Drives read_data back to the CPU with one-cycle registered latency. This matches the CPU fetch sequence, where MREAD is held for two cycles before the result is captured.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 9, address width.
- RAM_WORDS, 256, RAM depth; RAM occupies addresses 0..RAM_WORDS-1.
- LED_ADDR, 9'h100, write-only LED register address.
- SW_ADDR, 9'h140, read-only switch register address.
- IO_W, 8, LED/switch width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_cmd  in  2  command: 1=MREAD, 3=MWRITE, 2=MNONE; 0 is also treated as MNONE.
- mem_addr  in  ADDR_W  word address.
- write_data  in  DATA_W  store data, valid with MWRITE.
- read_data  out  DATA_W  registered read result.
- rd_valid  out  1  pulses high for one cycle when read_data was updated by a read.
- err  out  1  pulses high for one cycle on an access to an unmapped address.
- sw_in  in  IO_W  asynchronous switch inputs.
- led_out  out  IO_W  LED register.
- rd_count  out  16  saturating count of accepted reads.
- wr_count  out  16  saturating count of accepted writes.

Behaviour:
- Reset (asynchronous, active-high):
  - read_data, rd_valid, err, led_out, rd_count, wr_count, and both switch synchroniser stages all go to 0.
  - RAM contents are not reset.
  - While reset is high, no write or read takes effect. A command present in the same cycle reset deasserts is ignored until the next rising edge.
- Address decode, evaluated from mem_addr at the rising edge:
  - RAM if mem_addr < RAM_WORDS.
  - LED if mem_addr == LED_ADDR.
  - SW if mem_addr == SW_ADDR.
  - Otherwise unmapped.
- MREAD sampled at edge N:
  - RAM: read_data <= ram[mem_addr].
  - SW: read_data <= zero-extended sw_sync.
  - LED: read_data <= zero-extended led_out (read-back allowed).
  - Unmapped: read_data <= 0 and err = 1.
  - rd_valid = 1 for the cycle after edge N; rd_count increments.
  - Latency: data is visible after edge N. The CPU holding MREAD across cycles N-1 and N sees valid data before edge N+1.
- MWRITE sampled at edge N:
  - RAM: ram[mem_addr] <= write_data.
  - LED: led_out <= write_data[IO_W-1:0].
  - SW: write ignored and err = 1.
  - Unmapped: write ignored and err = 1.
  - wr_count increments on every MWRITE, including ignored ones. read_data holds its value.
- MNONE/0: no state change; read_data holds its last value; rd_valid = 0; err = 0.
- Back-to-back write then read of the same address: the read returns the newly written data, because the write lands at edge N and the read samples at edge N+1.
- Repeated MREAD at a constant address re-reads every cycle; rd_valid stays high.
- Switch synchroniser: two flip-flops, sw_sync = stage2. A change on sw_in is visible in a SW read issued two edges later.
- Counters saturate at 16'hFFFF and never wrap.
- err and rd_valid are single-cycle registered pulses, re-evaluated every edge.
- mem_addr and write_data are don't-care when mem_cmd is MNONE; no X may propagate into state.
- No wait states; every command completes in one edge. The block has no ready output.

Test Plan:
- Reset mid-operation: reset high, then MWRITE addr 5 data 16'hBEEF held for 2 edges, then reset low and MNONE → ram[5] unchanged; all outputs 0.
- Write/read RAM: MWRITE addr 9'h003 data 16'h1234 at edge 1, MREAD addr 3 at edge 2 → read_data = 16'h1234 after edge 2; rd_valid pulses; wr_count = 1, rd_count = 1.
- LED write and readback: MWRITE addr 9'h100 data 16'hA55A → led_out = 8'h5A; MREAD addr 9'h100 → read_data = 16'h005A.
- Switch read: sw_in = 8'h3C, then MREAD SW_ADDR at the first edge → stale 0; MREAD repeated at the third edge → read_data = 16'h003C.
- Unmapped and illegal accesses: MREAD addr 9'h1F0 → read_data = 0, err pulses 1 cycle; MWRITE addr 9'h140 → err pulses, led_out and RAM unchanged, wr_count increments.
- Counter saturation: preload via 65 540 consecutive MREADs → rd_count = 16'hFFFF and stays there; MNONE cycles leave read_data holding its last value.
